// File: rtl/if_id_ctrl.sv
// Fetch/decode boundary sequencer: PC advance/hold/reload, IF/ID capture/hold/flush,
// ID/EX bubble injection and a one-entry replay buffer. Define IF_ID_CTRL_PERF_EN for perf counters.
module if_id_ctrl #(
  parameter int                 DATA_W       = 32,
  parameter logic [DATA_W-1:0]  NOP_INST     = 32'h00000013,
  parameter int                 FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_i,
  input  logic [DATA_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              muldiv_busy_i,
  input  logic [DATA_W-1:0] inst_i,
  input  logic              inst_valid_i,
  output logic              pc_hold_o,
  output logic              pc_load_o,
  output logic [DATA_W-1:0] pc_load_addr_o,
  output logic              if_id_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_hold_o,
  output logic              id_ex_flush_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [1:0]        state_o
`ifdef IF_ID_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  always_comb begin
    // NOTE: every output and next-state variable gets a default first so no path infers a latch.
    state_d        = ST_RUN;
    flush_cnt_d    = flush_cnt_q;
    buf_valid_d    = buf_valid_q;
    buf_d          = buf_q;
    pc_hold_o      = 1'b0;
    pc_load_o      = 1'b0;
    pc_load_addr_o = '0;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_hold_o   = 1'b0;
    id_ex_flush_o  = 1'b0;
    inst_o         = NOP_INST;
    inst_valid_o   = 1'b0;

    // Outputs stay at their reset values for as long as rst is high, without waiting for a clock.
    if (!rst) begin
      if (jump_req_i) begin
        pc_load_o      = 1'b1;
        pc_load_addr_o = jump_addr_i;
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        buf_valid_d    = 1'b0;
        flush_cnt_d    = 2'(FLUSH_CYCLES);
        state_d        = ST_FLUSH;
      end else if (state_q == ST_FLUSH) begin
        // Only the redirect target path lives past a redirect, so younger hazards are moot here.
        if_id_flush_o = 1'b1;
        flush_cnt_d   = (flush_cnt_q == 2'd0) ? 2'd0 : flush_cnt_q - 2'd1;
        state_d       = (flush_cnt_q <= 2'd1) ? ST_RUN : ST_FLUSH;
      end else if (muldiv_busy_i) begin
        pc_hold_o    = 1'b1;
        if_id_hold_o = 1'b1;
        id_ex_hold_o = 1'b1;
        state_d      = ST_WAIT;
      end else if (load_use_i) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
        state_d       = ST_STALL;
      end else if (buf_valid_q) begin
        // First released cycle: the parked instruction goes first, PC waits one more cycle.
        inst_o       = buf_q;
        inst_valid_o = 1'b1;
        pc_hold_o    = 1'b1;
        buf_valid_d  = 1'b0;
      end else begin
        inst_o       = inst_valid_i ? inst_i : NOP_INST;
        inst_valid_o = inst_valid_i;
      end

      if (if_id_hold_o && inst_valid_i && !buf_valid_q) begin
        buf_valid_d = 1'b1;
        buf_d       = inst_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      buf_valid_q <= 1'b0;
      buf_q       <= NOP_INST;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
    end
  end

  assign state_o = state_q;

`ifdef IF_ID_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (state_q == ST_STALL || state_q == ST_WAIT) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_req_i) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl: a per-cycle vector table plus hand-written
// sequences for simultaneous events and asynchronous reset during a mul/div wait.
module tb_if_id_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        load_use_i;
  logic        muldiv_busy_i;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        pc_hold_o, pc_load_o, if_id_hold_o, if_id_flush_o;
  logic        id_ex_hold_o, id_ex_flush_o, inst_valid_o;
  logic [31:0] pc_load_addr_o, inst_o;
  logic [1:0]  state_o;
`ifdef IF_ID_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  if_id_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .load_use_i     (load_use_i),
    .muldiv_busy_i  (muldiv_busy_i),
    .inst_i         (inst_i),
    .inst_valid_i   (inst_valid_i),
    .pc_hold_o      (pc_hold_o),
    .pc_load_o      (pc_load_o),
    .pc_load_addr_o (pc_load_addr_o),
    .if_id_hold_o   (if_id_hold_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_hold_o   (id_ex_hold_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o),
    .state_o        (state_o)
`ifdef IF_ID_CTRL_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // {pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, inst_valid, state[1:0]}
  logic [8:0] ctrl_now;
  assign ctrl_now = {pc_hold_o, pc_load_o, if_id_hold_o, if_id_flush_o,
                     id_ex_hold_o, id_ex_flush_o, inst_valid_o, state_o};

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        lu;
    logic        busy;
    logic [31:0] inst;
    logic        iv;
    logic [8:0]  exp_ctrl;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] c(input logic ph, input logic pl, input logic ih, input logic ifl,
                                   input logic eh, input logic ef, input logic iv, input logic [1:0] st);
    return {ph, pl, ih, ifl, eh, ef, iv, st};
  endfunction

  function automatic vec_t mk(input logic j, input logic [31:0] a, input logic lu, input logic b,
                              input logic [31:0] ins, input logic iv, input logic [8:0] ec,
                              input logic [31:0] ei, input logic [31:0] ea);
    vec_t v;
    v.jump = j; v.addr = a; v.lu = lu; v.busy = b; v.inst = ins; v.iv = iv;
    v.exp_ctrl = ec; v.exp_inst = ei; v.exp_addr = ea;
    return v;
  endfunction

  task automatic drive(input logic j, input logic [31:0] a, input logic lu, input logic b,
                       input logic [31:0] ins, input logic iv);
    jump_req_i    = j;
    jump_addr_i   = a;
    load_use_i    = lu;
    muldiv_busy_i = b;
    inst_i        = ins;
    inst_valid_i  = iv;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [8:0] ec,
                               input logic [31:0] ei, input logic [31:0] ea);
    check({tag, "_ctrl"}, 64'(ctrl_now), 64'(ec));
    check({tag, "_inst"}, 64'(inst_o), 64'(ei));
    check({tag, "_addr"}, 64'(pc_load_addr_o), 64'(ea));
  endtask

  // One cycle: inputs change just after the rising edge, outputs are sampled mid-cycle.
  task automatic cycle(input string tag, input logic j, input logic [31:0] a, input logic lu,
                       input logic b, input logic [31:0] ins, input logic iv,
                       input logic [8:0] ec, input logic [31:0] ei, input logic [31:0] ea);
    @(posedge clk);
    #1 drive(j, a, lu, b, ins, iv);
    #3 check_outputs(tag, ec, ei, ea);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Per-cycle table, starting from the first cycle after reset release.
    vecs.push_back(mk(0, 0, 0, 0, 32'h00500093, 1, c(0,0,0,0,0,0,1,0), 32'h00500093, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00000000, 0, c(0,0,0,0,0,0,0,0), NOP, 0));
    vecs.push_back(mk(1, 32'h80, 0, 0, 32'h00600113, 1, c(0,1,0,1,0,1,0,0), NOP, 32'h80));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00700193, 1, c(0,0,0,1,0,0,0,3), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00800213, 1, c(0,0,0,0,0,0,1,0), 32'h00800213, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00000000, 0, c(1,0,1,0,0,1,0,0), NOP, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h00000000, 0, c(1,0,1,0,0,1,0,1), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00900293, 1, c(0,0,0,0,0,0,1,1), 32'h00900293, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00000000, 0, c(1,0,1,0,1,0,0,0), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h002081b3, 1, c(1,0,1,0,1,0,0,2), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00000000, 0, c(1,0,1,0,1,0,0,2), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00000000, 0, c(1,0,1,0,1,0,0,2), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00000000, 0, c(1,0,1,0,1,0,0,2), NOP, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00000000, 0, c(1,0,0,0,0,0,1,2), 32'h002081b3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h00a00313, 1, c(0,0,0,0,0,0,1,0), 32'h00a00313, 0));

    // Reset held with active inputs: outputs must still show reset values.
    rst = 1'b1;
    drive(1, 32'h80, 1, 1, 32'h00500093, 1);
    @(posedge clk);
    @(posedge clk);
    #4 check_outputs("reset", c(0,0,0,0,0,0,0,0), NOP, 0);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].jump, vecs[i].addr, vecs[i].lu, vecs[i].busy,
            vecs[i].inst, vecs[i].iv, vecs[i].exp_ctrl, vecs[i].exp_inst, vecs[i].exp_addr);
    end

    // Simultaneous redirect, mul/div busy and load-use with a full buffer: redirect wins, buffer dropped.
    cycle("sim_fill", 0, 0, 0, 1, 32'h00b00393, 1, c(1,0,1,0,1,0,0,0), NOP, 0);
    cycle("sim_all",  1, 32'h100, 1, 1, 32'h0, 0, c(0,1,0,1,0,1,0,2), NOP, 32'h100);
    cycle("sim_flush", 0, 0, 0, 0, 32'h00c00413, 1, c(0,0,0,1,0,0,0,3), NOP, 0);
    cycle("sim_run",  0, 0, 0, 0, 32'h00d00493, 1, c(0,0,0,0,0,0,1,0), 32'h00d00493, 0);

    // Asynchronous reset in WAIT with a buffered instruction: immediate reset, buffer discarded.
    cycle("wait_fill", 0, 0, 0, 1, 32'h00e00513, 1, c(1,0,1,0,1,0,0,0), NOP, 0);
    cycle("wait_hold", 0, 0, 0, 1, 32'h0, 0, c(1,0,1,0,1,0,0,2), NOP, 0);
    #1 rst = 1'b1;
    #1 check_outputs("async_rst", c(0,0,0,0,0,0,0,0), NOP, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 32'h00f00593, 1);
    #3 check_outputs("post_rst", c(0,0,0,0,0,0,1,0), 32'h00f00593, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
